// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: D-cache write-through stores, then D-cache fills, then
// I-cache fills. Fills stream one block of word reads and return each word to the owner.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           d_wr,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [DATA_W-1:0]              d_wr_data,
  output logic                           d_wr_ack,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_valid,
  output logic [DATA_W-1:0]              fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_fill_we,
  output logic                           d_fill_we,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic                           busy
);

  localparam int WB = $clog2(BLOCK_WORDS);
  localparam int CW = WB + 1;
  localparam int QW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {QUIET, IDLE, WRITE, FILL, RECOVER} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_iss_cnt;
  logic [CW-1:0]     r_ret_cnt;
  logic [QW-1:0]     r_q_cnt;
  logic              r_own_i;
  logic              r_own_d;
  logic [ADDR_W-1:0] r_base;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_wr_ack;
  logic              r_busy;

  logic              w_ret;
  logic              w_last;
  logic [ADDR_W-1:0] w_d_base;
  logic [ADDR_W-1:0] w_i_base;
  logic [ADDR_W-1:0] w_iss_addr;

  // Block base: clear the word-index bits plus the byte-in-word bit.
  assign w_d_base   = {d_miss_addr[ADDR_W-1:WB+1], {(WB+1){1'b0}}};
  assign w_i_base   = {i_miss_addr[ADDR_W-1:WB+1], {(WB+1){1'b0}}};
  assign w_iss_addr = r_base + ADDR_W'({r_iss_cnt, 1'b0});

  // Returns are taken only while filling and only up to a full block.
  assign w_ret  = (r_state == FILL) && mem_valid && (r_ret_cnt < CW'(BLOCK_WORDS));
  assign w_last = w_ret && (r_ret_cnt == CW'(BLOCK_WORDS - 1));

  assign fill_data   = w_ret ? mem_rdata : '0;
  assign fill_word   = w_ret ? r_ret_cnt[WB-1:0] : '0;
  assign i_fill_we   = w_ret & r_own_i;
  assign d_fill_we   = w_ret & r_own_d;
  assign i_fill_done = w_last & r_own_i;
  assign d_fill_done = w_last & r_own_d;

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign d_wr_ack  = r_wr_ack;
  assign busy      = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= QUIET;
      r_iss_cnt   <= '0;
      r_ret_cnt   <= '0;
      r_q_cnt     <= '0;
      r_own_i     <= 1'b0;
      r_own_d     <= 1'b0;
      r_base      <= '0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wr_ack    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wr_ack    <= 1'b0;
      case (r_state)
        // Reads issued before reset may still return; let them drain unseen.
        QUIET: begin
          if (r_q_cnt == QW'(MEM_LATENCY - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_q_cnt <= r_q_cnt + 1'b1;
            r_busy  <= 1'b1;
          end
        end
        IDLE: begin
          r_iss_cnt <= '0;
          r_ret_cnt <= '0;
          if (d_wr) begin
            r_state     <= WRITE;
            r_mem_en    <= 1'b1;
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= d_wr_addr;
            r_mem_wdata <= d_wr_data;
            r_wr_ack    <= 1'b1;
            r_busy      <= 1'b1;
          end else if (d_miss) begin
            r_state    <= FILL;
            r_own_d    <= 1'b1;
            r_base     <= w_d_base;
            r_mem_en   <= 1'b1;
            r_mem_addr <= w_d_base;
            r_iss_cnt  <= CW'(1);
            r_busy     <= 1'b1;
          end else if (i_miss) begin
            r_state    <= FILL;
            r_own_i    <= 1'b1;
            r_base     <= w_i_base;
            r_mem_en   <= 1'b1;
            r_mem_addr <= w_i_base;
            r_iss_cnt  <= CW'(1);
            r_busy     <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        WRITE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        FILL: begin
          if (r_iss_cnt < CW'(BLOCK_WORDS)) begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= w_iss_addr;
            r_iss_cnt  <= r_iss_cnt + 1'b1;
          end
          if (w_ret)
            r_ret_cnt <= r_ret_cnt + 1'b1;
          if (w_last)
            r_state <= RECOVER;
        end
        RECOVER: begin
          r_state <= IDLE;
          r_own_i <= 1'b0;
          r_own_d <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= QUIET;
          r_q_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-latency memory model returns addr^0x5A5A for
// each read; fills, writes, priority, wrap, reset abort and spurious returns are checked.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack, mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy;

  logic        spur = 1'b0;
  logic [15:0] spur_data = 16'h0;
  logic [3:0]  p_v = 4'h0;
  logic [15:0] p_a [4];
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Read data appears MEM_LATENCY (4) cycles after the cycle mem_en was high.
  always @(posedge clk) begin
    p_v    <= {p_v[2:0], mem_en & ~mem_wr};
    p_a[0] <= mem_addr;
    p_a[1] <= p_a[0];
    p_a[2] <= p_a[1];
    p_a[3] <= p_a[2];
  end
  assign mem_valid = p_v[3] | spur;
  assign mem_rdata = p_v[3] ? mdata(p_a[3]) : (spur ? spur_data : 16'h0);

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Follows one fill from request to done; drops the miss in the done cycle.
  task automatic expect_fill(input bit is_d, input logic [15:0] base,
                             output int first_cyc, output int done_cyc);
    int nis, nret, budget;
    bit fin;
    logic [15:0] a;
    nis = 0; nret = 0; budget = 0; fin = 1'b0;
    first_cyc = -1; done_cyc = -1;
    while (!fin && budget < 40) begin
      @(posedge clk); #1;
      budget++;
      if (mem_en) begin
        a = base + 16'(2 * nis);
        chk("fill_rd", 32'(mem_wr), 32'd0);
        chk("fill_addr", 32'(mem_addr), 32'(a));
        if (nis == 0) first_cyc = cyc;
        else chk("issue_b2b", cyc, first_cyc + nis);
        nis++;
      end else begin
        chk("idle_bus", {mem_addr, mem_wdata}, 32'd0);
      end
      chk("non_owner", is_d ? 32'({i_fill_we, i_fill_done}) : 32'({d_fill_we, d_fill_done}), 32'd0);
      if (is_d ? d_fill_we : i_fill_we) begin
        a = base + 16'(2 * nret);
        chk("fill_word", 32'(fill_word), nret);
        chk("fill_data", 32'(fill_data), 32'(mdata(a)));
        chk("fill_done", 32'(is_d ? d_fill_done : i_fill_done), 32'(nret == 7));
        if (nret == 7) begin
          fin = 1'b1;
          done_cyc = cyc;
          if (is_d) d_miss = 1'b0;
          else      i_miss = 1'b0;
        end
        nret++;
      end
    end
    chk("issues", nis, 8);
    chk("returns", nret, 8);
  endtask

  initial begin
    int rel, f, dn, f2, dn2, ack_cyc, n, late;
    bit seen;
    rst = 1'b1;
    i_miss = 0; d_miss = 0; d_wr = 0;
    i_miss_addr = 0; d_miss_addr = 0; d_wr_addr = 0; d_wr_data = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem", {mem_en, mem_wr, d_wr_ack, busy}, 32'd0);
    chk("rst_bus", {mem_addr, mem_wdata}, 32'd0);
    chk("rst_fill", {i_fill_we, d_fill_we, i_fill_done, d_fill_done, fill_word}, 32'd0);

    // D fill right after reset: 4 QUIET cycles, 1 IDLE, then issues
    @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc;
    d_miss_addr = 16'h1236;
    d_miss = 1'b1;
    expect_fill(1'b1, 16'h1230, f, dn);
    chk("quiet_lat", f - rel, 5);
    chk("fill_lat", dn - f, 11);
    @(posedge clk); #1;
    chk("busy_recover", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("busy_idle", 32'(busy), 32'd0);

    // Both misses: D block first, then RECOVER, IDLE, I issues
    d_miss_addr = 16'h4444;
    i_miss_addr = 16'h3008;
    d_miss = 1'b1;
    i_miss = 1'b1;
    expect_fill(1'b1, 16'h4440, f, dn);
    expect_fill(1'b0, 16'h3000, f2, dn2);
    chk("both_gap", f2 - dn, 3);
    chk("i_fill_lat", dn2 - f2, 11);

    // Store wins over simultaneous I miss
    d_wr_addr = 16'h0040;
    d_wr_data = 16'hBEEF;
    i_miss_addr = 16'h0056;
    d_wr = 1'b1;
    i_miss = 1'b1;
    seen = 1'b0;
    ack_cyc = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (d_wr_ack) begin
        seen = 1'b1;
        ack_cyc = cyc;
        chk("wr_cmd", {mem_en, mem_wr}, 32'd3);
        chk("wr_addr", 32'(mem_addr), 32'h0040);
        chk("wr_data", 32'(mem_wdata), 32'hBEEF);
        d_wr = 1'b0;
      end
    end
    chk("wr_ack_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    chk("wr_ack_pulse", {d_wr_ack, mem_en}, 32'd0);
    expect_fill(1'b0, 16'h0050, f, dn);
    chk("wr_then_fill", f - ack_cyc, 2);

    // Top-of-memory block: issues 0xFFF0..0xFFFE with no carry out
    i_miss_addr = 16'hFFF2;
    i_miss = 1'b1;
    expect_fill(1'b0, 16'hFFF0, f, dn);

    // Reset abort after three returned words
    i_miss_addr = 16'h2000;
    i_miss = 1'b1;
    n = 0;
    for (int k = 0; k < 30 && n < 3; k++) begin
      @(posedge clk); #1;
      if (i_fill_we) n++;
    end
    chk("abort_words", n, 3);
    #1 rst = 1'b1;
    #1;
    chk("abort_out", {mem_en, i_fill_we, i_fill_done, busy}, 32'd0);
    chk("abort_bus", {mem_addr, 13'd0, fill_word}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    late = 0;
    for (int k = 0; k < 4; k++) begin
      if (mem_valid) late++;
      chk("quiet_drop", {i_fill_we, i_fill_done, d_fill_we, mem_en}, 32'd0);
      @(posedge clk); #1;
    end
    chk("late_returns", late, 3);
    expect_fill(1'b0, 16'h2000, f, dn);

    // Spurious return in IDLE
    repeat (2) @(posedge clk);
    #1;
    spur_data = 16'h1111;
    spur = 1'b1;
    #1;
    chk("spur_we", {i_fill_we, d_fill_we, i_fill_done, d_fill_done}, 32'd0);
    @(posedge clk); #1;
    spur = 1'b0;
    chk("spur_idle", {busy, mem_en, i_fill_we, d_fill_we}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
